// File: rtl/muldiv_iter_unit_pkg.sv
// Shared types and op-decoding helpers for the iterative multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [2:0] {
      MULT  = 3'd0,
      MULTU = 3'd1,
      MADD  = 3'd2,
      MADDU = 3'd3,
      MSUB  = 3'd4,
      MSUBU = 3'd5,
      DIV   = 3'd6,
      DIVU  = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic logic is_signed(input op_t op);
      return (op == MULT) || (op == MADD) || (op == MSUB) || (op == DIV);
   endfunction

   function automatic logic is_div(input op_t op);
      return (op == DIV) || (op == DIVU);
   endfunction

   function automatic logic is_acc(input op_t op);
      return (op == MADD) || (op == MADDU) || (op == MSUB) || (op == MSUBU);
   endfunction

endpackage

// File: rtl/muldiv_iter_unit_if.sv
// EX-stage request/response bundle for muldiv_iter_unit.
interface muldiv_iter_unit_if #(parameter int WIDTH = 32);
   import muldiv_pkg::*;

   // Handshake: EX raises start_i with stable op/operands and holds it until it
   // sees ready_o; the request is taken only in IDLE. The result stays on
   // result_o with ready_o high until start_i drops. annul_i aborts at any edge.
   logic               start_i;
   logic               annul_i;
   op_t                op_i;
   logic [WIDTH-1:0]   opa_i;
   logic [WIDTH-1:0]   opb_i;
   logic [2*WIDTH-1:0] hilo_i;
   logic               busy_o;
   logic               ready_o;
   logic [2*WIDTH-1:0] result_o;

   modport master (
      output start_i, annul_i, op_i, opa_i, opb_i, hilo_i,
      input  busy_o, ready_o, result_o
   );

   modport slave (
      input  start_i, annul_i, op_i, opa_i, opb_i, hilo_i,
      output busy_o, ready_o, result_o
   );

endinterface

// File: rtl/muldiv_iter_unit_step.sv
// One iteration of the shared datapath: right-shifting shift-add multiply or
// left-shifting restoring divide, both on a {hi,lo} accumulator.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic               div_mode,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   operand,
   output logic [2*WIDTH-1:0] acc_next
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] rem_shift;
   logic [WIDTH:0] diff;

   always_comb begin
      sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      rem_shift = acc[2*WIDTH-1:WIDTH-1];
      diff      = rem_shift - {1'b0, operand};
      acc_next  = acc;
      if (div_mode) begin
         // diff cannot exceed WIDTH bits, so its top bit is a clean borrow flag
         if (!diff[WIDTH]) acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else              acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
         acc_next = {sum, acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative HI/LO multiply, multiply-accumulate and divide unit, one bit per
// cycle on operand magnitudes with the sign applied in a single FIXUP cycle.
module muldiv_iter_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   muldiv_iter_unit_if.slave  bus,
   output state_t             fsm_state
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam int W2 = 2 * WIDTH;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q;
   op_t               op_q;
   logic [WIDTH-1:0]  opnd_q;
   logic [W2-1:0]     acc_q;
   logic [W2-1:0]     hilo_q;
   logic              neg_q;
   logic              neg_rem_q;
   logic [W2-1:0]     result_q;

   logic              accept;
   logic              div0;
   logic              a_neg, b_neg;
   logic [WIDTH-1:0]  a_mag, b_mag;
   logic [W2-1:0]     step_acc;
   logic [W2-1:0]     prod;
   logic [WIDTH-1:0]  quo, rem;
   logic [W2-1:0]     fix_result;
   logic              busy, ready;

   always_comb begin
      accept = (state_q == IDLE) && bus.start_i && !bus.annul_i;
      div0   = is_div(bus.op_i) && (bus.opb_i == '0);
      a_neg  = is_signed(bus.op_i) && bus.opa_i[WIDTH-1];
      b_neg  = is_signed(bus.op_i) && bus.opb_i[WIDTH-1];
      a_mag  = a_neg ? -bus.opa_i : bus.opa_i;
      b_mag  = b_neg ? -bus.opb_i : bus.opb_i;
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .div_mode (is_div(op_q)),
      .acc      (acc_q),
      .operand  (opnd_q),
      .acc_next (step_acc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.annul_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:  if (bus.start_i) state_d = div0 ? DONE : BUSY;
            BUSY:  if (cnt_q == CW'(WIDTH - 1)) state_d = FIXUP;
            FIXUP: state_d = DONE;
            DONE:  if (!bus.start_i) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (state_q == BUSY) || (state_q == FIXUP);
      ready = (state_q == DONE);
   end

   // Remainder follows the dividend; product and quotient follow the sign xor.
   always_comb begin
      prod = neg_q ? -acc_q : acc_q;
      quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem  = neg_rem_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
      if (is_div(op_q))                         fix_result = {rem, quo};
      else if ((op_q == MADD) || (op_q == MADDU)) fix_result = hilo_q + prod;
      else if ((op_q == MSUB) || (op_q == MSUBU)) fix_result = hilo_q - prod;
      else                                      fix_result = prod;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         op_q      <= MULT;
         opnd_q    <= '0;
         acc_q     <= '0;
         hilo_q    <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
      end else if (accept) begin
         cnt_q     <= '0;
         op_q      <= bus.op_i;
         hilo_q    <= bus.hilo_i;
         neg_q     <= a_neg ^ b_neg;
         neg_rem_q <= a_neg;
         if (is_div(bus.op_i)) begin
            opnd_q <= b_mag;
            acc_q  <= {{WIDTH{1'b0}}, a_mag};
         end else begin
            opnd_q <= a_mag;
            acc_q  <= {{WIDTH{1'b0}}, b_mag};
         end
         if (div0) result_q <= {bus.opa_i, {WIDTH{1'b1}}};
      end else if (!bus.annul_i && (state_q == BUSY)) begin
         acc_q <= step_acc;
         cnt_q <= cnt_q + CW'(1);
      end else if (!bus.annul_i && (state_q == FIXUP)) begin
         result_q <= fix_result;
      end
   end

   assign bus.busy_o   = busy;
   assign bus.ready_o  = ready;
   assign bus.result_o = result_q;
   assign fsm_state    = state_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Randomized scoreboard bench for muldiv_iter_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_iter_unit;
   import muldiv_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   muldiv_iter_unit_if #(.WIDTH(32)) bus32 ();
   muldiv_iter_unit_if #(.WIDTH(8))  bus8 ();
   state_t st32, st8;

   muldiv_iter_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32), .fsm_state(st32));
   muldiv_iter_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8),  .fsm_state(st8));

   int n_tests = 0;
   int n_fail  = 0;
   logic [63:0] exp32_q[$];
   logic [15:0] exp8_q[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain signed/unsigned arithmetic on wide integers.
   function automatic logic [127:0] model(input int w, input op_t op, input logic [63:0] a,
                                          input logic [63:0] b, input logic [127:0] hilo);
      logic signed [131:0] sa, sb, res;
      logic [131:0] m1, m2, q, r;
      logic sgn;
      sgn = (op == MULT) || (op == MADD) || (op == MSUB) || (op == DIV);
      m1 = (132'd1 << w) - 132'd1;
      m2 = (132'd1 << (2 * w)) - 132'd1;
      sa = {68'd0, a};
      sb = {68'd0, b};
      if (sgn && a[w-1]) sa = sa - (132'sd1 <<< w);
      if (sgn && b[w-1]) sb = sb - (132'sd1 <<< w);
      case (op)
         DIV, DIVU: begin
            if (b == 64'd0) res = ({68'd0, a} << w) | m1;
            else begin
               q = sa / sb;
               r = sa % sb;
               res = ((r & m1) << w) | (q & m1);
            end
         end
         MADD, MADDU: res = {4'd0, hilo} + sa * sb;
         MSUB, MSUBU: res = {4'd0, hilo} - sa * sb;
         default:     res = sa * sb;
      endcase
      res = res & m2;
      return res[127:0];
   endfunction

   function automatic logic [63:0] pick(input int w);
      logic [63:0] mask;
      mask = (64'd1 << w) - 64'd1;
      case ($urandom_range(0, 7))
         0: return 64'd0;
         1: return 64'd1;
         2: return mask;
         3: return 64'd1 << (w - 1);
         4: return 64'($urandom_range(0, 15));
         default: return {$urandom, $urandom} & mask;
      endcase
   endfunction

   function automatic int exp_lat(input int w, input op_t op, input logic [63:0] b);
      return ((op == DIV || op == DIVU) && b == 64'd0) ? 1 : w + 2;
   endfunction

   // Monitors: pop one expectation on every rising ready.
   logic rdy32_prev = 1'b0;
   logic rdy8_prev  = 1'b0;
   always @(negedge clk) begin
      if (bus32.ready_o && !rdy32_prev) begin
         if (exp32_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL result32: ready rose with %0h, no expected result", bus32.result_o);
         end else check("result32", bus32.result_o, exp32_q.pop_front());
      end
      if (bus8.ready_o && !rdy8_prev) begin
         if (exp8_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL result8: ready rose with %0h, no expected result", bus8.result_o);
         end else check("result8", bus8.result_o, exp8_q.pop_front());
      end
      rdy32_prev = bus32.ready_o;
      rdy8_prev  = bus8.ready_o;
   end

   task automatic op32(input op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] hilo, output int lat, output int bc);
      logic [127:0] m;
      @(posedge clk); #1;
      bus32.op_i = op; bus32.opa_i = a; bus32.opb_i = b; bus32.hilo_i = hilo;
      bus32.start_i = 1'b1;
      m = model(32, op, {32'd0, a}, {32'd0, b}, {64'd0, hilo});
      exp32_q.push_back(m[63:0]);
      lat = 0; bc = 0;
      while (!bus32.ready_o && lat < 200) begin
         @(posedge clk); #1;
         lat++;
         if (bus32.busy_o) bc++;
      end
      bus32.start_i = 1'b0;
      @(posedge clk); #1;
      check("ready32_drop", bus32.ready_o, 0);
   endtask

   task automatic op8(input op_t op, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] hilo, output int lat);
      logic [127:0] m;
      @(posedge clk); #1;
      bus8.op_i = op; bus8.opa_i = a; bus8.opb_i = b; bus8.hilo_i = hilo;
      bus8.start_i = 1'b1;
      m = model(8, op, {56'd0, a}, {56'd0, b}, {112'd0, hilo});
      exp8_q.push_back(m[15:0]);
      lat = 0;
      while (!bus8.ready_o && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      bus8.start_i = 1'b0;
      @(posedge clk); #1;
      check("ready8_drop", bus8.ready_o, 0);
   endtask

   initial begin
      int lat, bc;
      op_t op;
      logic [63:0] a, b, h;

      bus32.start_i = 0; bus32.annul_i = 0; bus32.op_i = MULT;
      bus32.opa_i = 0; bus32.opb_i = 0; bus32.hilo_i = 0;
      bus8.start_i = 0; bus8.annul_i = 0; bus8.op_i = MULT;
      bus8.opa_i = 0; bus8.opb_i = 0; bus8.hilo_i = 0;
      rst = 1'b1;
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy32", bus32.busy_o, 0);
      check("rst_ready32", bus32.ready_o, 0);
      check("rst_result32", bus32.result_o, 0);
      check("rst_state32", st32, IDLE);
      check("rst_result8", bus8.result_o, 0);
      @(negedge clk) rst = 1'b1;

      op32(MULT, 32'hFFFFFFFD, 32'd5, 64'd0, lat, bc);
      check("mult_lat", lat, 34);
      check("mult_busy_cycles", bc, 33);
      op32(MSUB, 32'd3, 32'd4, 64'h10, lat, bc);
      check("msub_lat", lat, 34);
      op32(MADDU, 32'hFFFFFFFF, 32'd2, 64'd1, lat, bc);
      op32(DIV, 32'hFFFFFFF9, 32'd2, 64'd0, lat, bc);
      op32(DIV, 32'h80000000, 32'hFFFFFFFF, 64'd0, lat, bc);
      check("div_ovf_lat", lat, 34);

      // divide by zero, then hold start for three more cycles
      @(posedge clk); #1;
      bus32.op_i = DIVU; bus32.opa_i = 32'd7; bus32.opb_i = 32'd0; bus32.start_i = 1'b1;
      exp32_q.push_back(64'h00000007_FFFFFFFF);
      @(posedge clk); #1;
      check("div0_ready_edge1", bus32.ready_o, 1);
      check("div0_busy", bus32.busy_o, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("div0_hold_ready", bus32.ready_o, 1);
         check("div0_hold_result", bus32.result_o, 64'h00000007_FFFFFFFF);
      end
      bus32.start_i = 1'b0;
      @(posedge clk); #1;
      check("div0_idle", st32, IDLE);
      check("div0_ready_low", bus32.ready_o, 0);
      check("idle_result_kept", bus32.result_o, 64'h00000007_FFFFFFFF);

      // annul in BUSY, then a fresh start
      @(posedge clk); #1;
      bus32.op_i = DIVU; bus32.opa_i = 32'd100; bus32.opb_i = 32'd7; bus32.start_i = 1'b1;
      repeat (9) @(posedge clk);
      #1;
      check("annul_pre_busy", bus32.busy_o, 1);
      bus32.annul_i = 1'b1; bus32.start_i = 1'b0;
      @(posedge clk); #1;
      bus32.annul_i = 1'b0;
      check("annul_state", st32, IDLE);
      check("annul_busy", bus32.busy_o, 0);
      check("annul_ready", bus32.ready_o, 0);
      op32(DIVU, 32'd100, 32'd7, 64'd0, lat, bc);
      check("after_annul_lat", lat, 34);

      // asynchronous reset mid-BUSY
      @(posedge clk); #1;
      bus32.op_i = MULTU; bus32.opa_i = 32'd9; bus32.opb_i = 32'd9; bus32.start_i = 1'b1;
      repeat (5) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("arst_busy", bus32.busy_o, 0);
      check("arst_ready", bus32.ready_o, 0);
      check("arst_result", bus32.result_o, 0);
      check("arst_state", st32, IDLE);
      bus32.start_i = 1'b0;
      @(negedge clk) rst = 1'b1;
      op32(MULTU, 32'd9, 32'd9, 64'd0, lat, bc);
      check("after_rst_lat", lat, 34);

      for (int i = 0; i < 40; i++) begin
         op = op_t'($urandom_range(0, 7));
         a = pick(32); b = pick(32); h = {$urandom, $urandom};
         op32(op, a[31:0], b[31:0], h, lat, bc);
         check("rand32_lat", lat, exp_lat(32, op, b));
      end

      op8(MULTU, 8'hFF, 8'hFF, 16'd0, lat);
      check("w8_multu_lat", lat, 10);
      op8(DIV, 8'h80, 8'hFF, 16'd0, lat);
      for (int i = 0; i < 30; i++) begin
         op = op_t'($urandom_range(0, 7));
         a = pick(8); b = pick(8); h = 64'($urandom_range(0, 65535));
         op8(op, a[7:0], b[7:0], h[15:0], lat);
         check("rand8_lat", lat, exp_lat(8, op, b));
      end

      repeat (3) @(posedge clk);
      check("exp32_q_drained", exp32_q.size(), 0);
      check("exp8_q_drained", exp8_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
Parametrised iterative multiply/divide unit shared by the EX stage for all HI/LO-producing arithmetic: MULT/MULTU, MADD/MADDU, MSUB/MSUBU, DIV/DIVU.
- Computes one bit per cycle, replacing the single-cycle multiplier and the two-pass MADD/MSUB stall scheme.
- EX holds start_i and stalls the pipeline until ready_o.
- annul_i lets the pipeline flush an in-flight operation.

Parameters:
WIDTH, 32, operand width in bits; result is 2*WIDTH (HI:LO); legal range 4..64.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
start_i  in  1  request; level held by EX until ready_o is seen
annul_i  in  1  flush; abort the current operation
op_i  in  3  operation code (package enum)
opa_i  in  WIDTH  multiplicand / dividend
opb_i  in  WIDTH  multiplier / divisor
hilo_i  in  2*WIDTH  forwarded {HI,LO}; used only by MADD*/MSUB*
busy_o  out  1  high in BUSY and FIXUP
ready_o  out  1  result valid
result_o  out  2*WIDTH  {HI,LO}; for divide, HI = remainder and LO = quotient

Behaviour:
- Reset (rst low, asynchronous): state IDLE, busy_o=0, ready_o=0, result_o=0, and all internal registers cleared.
- States: IDLE, BUSY, FIXUP, DONE.
- IDLE, on start_i=1 and annul_i=0, samples op_i, opa_i, opb_i and hilo_i.
  - Signed ops (MULT, MADD, MSUB, DIV) store the magnitudes of the operands plus a negate flag.
  - DIV/DIVU with opb_i==0: go to DONE next cycle with result_o = {opa_i, all-ones}; no iteration.
  - Otherwise: clear the iteration counter and go to BUSY.
- BUSY performs exactly WIDTH iterations.
  - Multiply: shift-add of the 2*WIDTH partial product.
  - Divide: restoring step producing one quotient bit per cycle.
  - Counter width is clog2(WIDTH)+1. When the counter reaches WIDTH-1, go to FIXUP.
- FIXUP takes one cycle.
  - Apply the sign: product is negated if the operand signs differ; quotient is negated if the signs differ; remainder takes the dividend's sign.
  - MADD*: result = hilo + product. MSUB*: result = hilo − product. Both are mod 2^(2*WIDTH).
  - Register the result, then go to DONE.
- DONE: ready_o=1 and result_o is held stable. Stay in DONE while start_i=1; go to IDLE when start_i=0.
  - result_o keeps its last value in IDLE.
  - ready_o is low in every state except DONE.
- Latency: with start sampled at edge 0, ready_o rises after edge WIDTH+2 (34 cycles at WIDTH=32). Divide-by-zero: ready_o rises after edge 1.
- annul_i=1 at any edge, in any state, forces IDLE and clears ready_o. It has priority over start_i, so no new operation starts that cycle.
- start_i toggling while BUSY/FIXUP is ignored. Operands are sampled only in IDLE.
- Signed DIV of most-negative / −1: quotient = most-negative (wraps), remainder = 0, with no exception.
- Unsigned ops never negate. hilo_i is ignored for MULT*/DIV*.
- Asynchronous reset mid-operation: immediate return to IDLE; the next start after reset release behaves normally.

Decomposition:
- Shared package, muldiv_pkg:
  - op enum, 3 bits: MULT=0, MULTU=1, MADD=2, MADDU=3, MSUB=4, MSUBU=5, DIV=6, DIVU=7.
  - state enum.
  - helper functions is_signed(op), is_div(op), is_acc(op).
- One natural sub-module, muldiv_step: a combinational single-iteration datapath (shift-add or restoring subtract), selected by is_div.
- The FSM, counter and FIXUP logic stay in muldiv_iter_unit.

Test Plan:
- MULT opa=0xFFFFFFFD (−3), opb=5, WIDTH=32 → ready_o after edge 34; result_o = 0xFFFFFFFF_FFFFFFF1; busy_o high for 33 cycles.
- MSUB opa=3, opb=4, hilo_i=0x00000000_00000010 → result_o = 0x00000000_00000004. MADDU opa=0xFFFFFFFF, opb=2, hilo_i=1 → 0x00000001_FFFFFFFF.
- DIV opa=0xFFFFFFF9 (−7), opb=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU opa=7, opb=0 → ready_o after edge 1; result_o = 0x00000007_FFFFFFFF. Hold start_i for 3 more cycles → ready_o and result_o stay stable; drop start_i → IDLE next edge.
- DIVU 100/7 with annul_i pulsed at edge 10 → IDLE, ready_o never rises. Start DIVU 100/7 at edge 12 → ready_o after edge 46, result_o = 0x00000002_0000000E. Assert rst mid-BUSY → outputs 0 immediately.
- WIDTH=8 instance: MULTU 0xFF*0xFF → result_o = 0xFE01 with ready_o after edge 10; DIV 0x80/0xFF → 0x0080.
